// File: rtl/post_process_pipe.sv
`default_nettype none
// ============================================================================
// Module      : post_process_pipe
// Description : Pipelined CORDIC post-processing stage. Converts two unsigned
//               fixed-point magnitudes (sin, cos) to IEEE-754 single precision,
//               applies the quadrant swap / sign, and presents the results
//               through a valid/ready handshake. Three elastic register
//               stages, latency 3, one sample per cycle when unstalled.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IN_W    input magnitude width (24..40)
//   FRAC_W  fractional bits of the input magnitudes
//   MAX_LZ  leading-zero count above which a channel flushes to +/-0
//   ROUND   1 = round-to-nearest-even, 0 = truncate
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   in_valid   in   1     input sample valid
//   in_ready   out  1     block can accept a sample this cycle
//   sign       in   1     angle sign
//   quadrant   in   2     angle quadrant 0..3
//   pre_sin    in   IN_W  unsigned sin magnitude
//   pre_cos    in   IN_W  unsigned cos magnitude
//   out_valid  out  1     result valid
//   out_ready  in   1     downstream accepts result
//   post_sin   out  32    IEEE-754 sin
//   post_cos   out  32    IEEE-754 cos
//   out_flush  out  2     {cos,sin} channel flushed to zero (after swap)
// ============================================================================
module post_process_pipe #(
    parameter int IN_W   = 30,
    parameter int FRAC_W = 28,
    parameter int MAX_LZ = 10,
    parameter int ROUND  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sign,
    input  logic [1:0]      quadrant,
    input  logic [IN_W-1:0] pre_sin,
    input  logic [IN_W-1:0] pre_cos,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     post_sin,
    output logic [31:0]     post_cos,
    output logic [1:0]      out_flush
);

    localparam int c_LZ_W    = $clog2(IN_W + 1);
    // Normalised magnitude padded with zeros so that guard/sticky positions
    // always exist, even when fewer than 23 bits sit below the leading one.
    localparam int c_EXT_W   = IN_W + 24;
    // Exponent of a sample whose leading one is at bit IN_W-1 (lz = 0).
    localparam int c_EXP_ADJ = 127 + IN_W - 1 - FRAC_W;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [c_LZ_W-1:0] f_lzc(input logic [IN_W-1:0] v);
        logic [c_LZ_W-1:0] n;
        logic              found;
        n     = c_LZ_W'(IN_W);
        found = 1'b0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = c_LZ_W'(IN_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Returns {flush, 31-bit magnitude field (exponent, mantissa)}.
    function automatic logic [31:0] f_convert(input logic [IN_W-1:0]   mag,
                                              input logic [c_LZ_W-1:0] lz);
        logic [c_EXT_W-1:0] ext;
        logic [22:0]        man;
        logic               g;
        logic               s;
        logic               rnd;
        logic [23:0]        man_r;
        int                 e;
        logic               fl;
        ext   = {mag << lz, 24'b0};
        man   = ext[c_EXT_W-2 -: 23];
        g     = ext[c_EXT_W-25];
        s     = |ext[c_EXT_W-26:0];
        rnd   = (ROUND != 0) && g && (s || man[0]);
        man_r = {1'b0, man} + 24'(rnd);
        // A carry out of the mantissa leaves man_r[22:0] at zero and bumps
        // the exponent by one.
        e     = c_EXP_ADJ - int'(lz) + int'(man_r[23]);
        fl    = (mag == '0) || (int'(lz) > MAX_LZ) || (e <= 0);
        if (fl) begin
            return {1'b1, 31'b0};
        end else if (e >= 255) begin
            return {1'b0, 8'hFF, 23'b0};
        end else begin
            return {1'b0, 8'(e), man_r[22:0]};
        end
    endfunction

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [1:0]        r_s1_quad;
    logic [IN_W-1:0]   r_s1_sin;
    logic [IN_W-1:0]   r_s1_cos;
    logic [c_LZ_W-1:0] r_s1_lz_sin;
    logic [c_LZ_W-1:0] r_s1_lz_cos;

    logic              r_s2_valid;
    logic              r_s2_sign;
    logic [1:0]        r_s2_quad;
    logic [30:0]       r_s2_fs;
    logic [30:0]       r_s2_fc;
    logic              r_s2_fl_sin;
    logic              r_s2_fl_cos;

    logic              r_s3_valid;
    logic [31:0]       r_post_sin;
    logic [31:0]       r_post_cos;
    logic [1:0]        r_out_flush;

    // Ready chain: a stage can load when empty or when its content moves on.
    logic w_s3_ready;
    logic w_s2_ready;
    logic w_s1_ready;

    assign w_s3_ready = ~r_s3_valid | out_ready;
    assign w_s2_ready = ~r_s2_valid | w_s3_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;

    // ------------------------------------------------------------------
    // Stage 1: capture and count leading zeros
    // ------------------------------------------------------------------
    logic [c_LZ_W-1:0] w_lz_sin;
    logic [c_LZ_W-1:0] w_lz_cos;

    assign w_lz_sin = f_lzc(pre_sin);
    assign w_lz_cos = f_lzc(pre_cos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_quad   <= 2'd0;
            r_s1_sin    <= '0;
            r_s1_cos    <= '0;
            r_s1_lz_sin <= '0;
            r_s1_lz_cos <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign   <= sign;
                r_s1_quad   <= quadrant;
                r_s1_sin    <= pre_sin;
                r_s1_cos    <= pre_cos;
                r_s1_lz_sin <= w_lz_sin;
                r_s1_lz_cos <= w_lz_cos;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise, round, build exponent, flush detection
    // ------------------------------------------------------------------
    logic [31:0] w_conv_sin;
    logic [31:0] w_conv_cos;

    assign w_conv_sin = f_convert(r_s1_sin, r_s1_lz_sin);
    assign w_conv_cos = f_convert(r_s1_cos, r_s1_lz_cos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_quad   <= 2'd0;
            r_s2_fs     <= '0;
            r_s2_fc     <= '0;
            r_s2_fl_sin <= 1'b0;
            r_s2_fl_cos <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign   <= r_s1_sign;
                r_s2_quad   <= r_s1_quad;
                r_s2_fs     <= w_conv_sin[30:0];
                r_s2_fc     <= w_conv_cos[30:0];
                r_s2_fl_sin <= w_conv_sin[31];
                r_s2_fl_cos <= w_conv_cos[31];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: quadrant swap and sign
    // ------------------------------------------------------------------
    logic [31:0] w_map_sin;
    logic [31:0] w_map_cos;
    logic [1:0]  w_map_flush;

    always_comb begin
        w_map_sin   = {r_s2_sign, r_s2_fs};
        w_map_cos   = {1'b0, r_s2_fc};
        w_map_flush = {r_s2_fl_cos, r_s2_fl_sin};
        case (r_s2_quad)
            2'd0: begin
                w_map_sin   = {r_s2_sign, r_s2_fs};
                w_map_cos   = {1'b0, r_s2_fc};
                w_map_flush = {r_s2_fl_cos, r_s2_fl_sin};
            end
            2'd1: begin
                w_map_sin   = {r_s2_sign, r_s2_fc};
                w_map_cos   = {1'b1, r_s2_fs};
                w_map_flush = {r_s2_fl_sin, r_s2_fl_cos};
            end
            2'd2: begin
                w_map_sin   = {~r_s2_sign, r_s2_fs};
                w_map_cos   = {1'b1, r_s2_fc};
                w_map_flush = {r_s2_fl_cos, r_s2_fl_sin};
            end
            default: begin
                w_map_sin   = {~r_s2_sign, r_s2_fc};
                w_map_cos   = {1'b0, r_s2_fs};
                w_map_flush = {r_s2_fl_sin, r_s2_fl_cos};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid  <= 1'b0;
            r_post_sin  <= '0;
            r_post_cos  <= '0;
            r_out_flush <= 2'b00;
        end else if (w_s3_ready) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_post_sin  <= w_map_sin;
                r_post_cos  <= w_map_cos;
                r_out_flush <= w_map_flush;
            end
        end
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_s3_valid;
    assign post_sin  = r_post_sin;
    assign post_cos  = r_post_cos;
    assign out_flush = r_out_flush;

endmodule
`default_nettype wire

// File: tb/tb_post_process_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_post_process_pipe
// Description : Directed self-checking bench for post_process_pipe. Two
//               instances share the stimulus: one rounding, one truncating.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_post_process_pipe;

    localparam int c_IN_W = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_ready_t;
    logic              sign;
    logic [1:0]        quadrant;
    logic [c_IN_W-1:0] pre_sin;
    logic [c_IN_W-1:0] pre_cos;
    logic              out_valid;
    logic              out_valid_t;
    logic              out_ready;
    logic [31:0]       post_sin;
    logic [31:0]       post_cos;
    logic [1:0]        out_flush;
    logic [31:0]       post_sin_t;
    logic [31:0]       post_cos_t;
    logic [1:0]        out_flush_t;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    post_process_pipe #(.IN_W(c_IN_W), .FRAC_W(28), .MAX_LZ(10), .ROUND(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .quadrant  (quadrant),
        .pre_sin   (pre_sin),
        .pre_cos   (pre_cos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .post_sin  (post_sin),
        .post_cos  (post_cos),
        .out_flush (out_flush)
    );

    post_process_pipe #(.IN_W(c_IN_W), .FRAC_W(28), .MAX_LZ(10), .ROUND(0)) u_dut_trunc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .sign      (sign),
        .quadrant  (quadrant),
        .pre_sin   (pre_sin),
        .pre_cos   (pre_cos),
        .out_valid (out_valid_t),
        .out_ready (out_ready),
        .post_sin  (post_sin_t),
        .post_cos  (post_cos_t),
        .out_flush (out_flush_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one sample to an idle pipeline, wait for its result, check it,
    // then let it drain.
    task automatic send_and_check(input string tag, input logic s, input logic [1:0] q,
                                  input logic [29:0] ms, input logic [29:0] mc,
                                  input logic [31:0] e_sin, input logic [31:0] e_cos,
                                  input logic [1:0] e_fl, input logic [31:0] e_sin_trunc);
        int cycles;
        sign      = s;
        quadrant  = q;
        pre_sin   = ms;
        pre_cos   = mc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycles    = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cycles++;
        end while (!out_valid && cycles < 10);
        chk({tag, "_latency"}, 32'(cycles), 32'd3);
        chk({tag, "_sin"}, post_sin, e_sin);
        chk({tag, "_cos"}, post_cos, e_cos);
        chk({tag, "_flush"}, 32'(out_flush), 32'(e_fl));
        chk({tag, "_sin_trunc"}, post_sin_t, e_sin_trunc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int got;
        logic        held_v;
        logic [31:0] held_sin;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign      = 1'b0;
        quadrant  = 2'd0;
        pre_sin   = '0;
        pre_cos   = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_post_sin", post_sin, 32'h0);
        chk("rst_post_cos", post_cos, 32'h0);
        chk("rst_out_flush", 32'(out_flush), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic conversion, rounding and flush cases
        send_and_check("t1", 1'b0, 2'd0, 30'h10000000, 30'h08000000,
                       32'h3F800000, 32'h3F000000, 2'b00, 32'h3F800000);
        send_and_check("tie_even", 1'b0, 2'd0, 30'h10000010, 30'h08000000,
                       32'h3F800000, 32'h3F000000, 2'b00, 32'h3F800000);
        send_and_check("round_up", 1'b0, 2'd0, 30'h10000030, 30'h08000000,
                       32'h3F800002, 32'h3F000000, 2'b00, 32'h3F800001);
        send_and_check("carry", 1'b0, 2'd0, 30'h1FFFFFF0, 30'h08000000,
                       32'h40000000, 32'h3F000000, 2'b00, 32'h3FFFFFFF);
        send_and_check("flush", 1'b0, 2'd0, 30'h00020000, 30'h00000000,
                       32'h00000000, 32'h00000000, 2'b11, 32'h00000000);
        send_and_check("lz9", 1'b0, 2'd0, 30'h00100000, 30'h08000000,
                       32'h3B800000, 32'h3F000000, 2'b00, 32'h3B800000);
        send_and_check("q1", 1'b0, 2'd1, 30'h08000000, 30'h10000000,
                       32'h3F800000, 32'hBF000000, 2'b00, 32'h3F800000);
        send_and_check("q2", 1'b1, 2'd2, 30'h08000000, 30'h10000000,
                       32'h3F000000, 32'hBF800000, 2'b00, 32'h3F000000);
        send_and_check("q3_flush", 1'b0, 2'd3, 30'h00000000, 30'h10000000,
                       32'hBF800000, 32'h00000000, 2'b10, 32'hBF800000);

        // Stream 6 samples with a 5-cycle output stall
        acc    = 0;
        got    = 0;
        held_v = 1'b0;
        held_sin = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid  = (acc < 6);
            sign      = 1'b0;
            quadrant  = 2'd0;
            pre_sin   = 30'h10000000 >> acc;
            pre_cos   = 30'h08000000;
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                chk("stall_accepted", 32'(acc), 32'd3);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (held_v) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_sin", post_sin, held_sin);
            end
            held_v   = out_valid && !out_ready;
            held_sin = post_sin;
            if (out_valid && out_ready) begin
                chk("stream_order", post_sin, 32'h3F800000 - (32'(got) << 23));
                got++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(got), 32'd6);
        #1;
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Reset with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pre_sin   = 30'h10000000;
        pre_cos   = 30'h08000000;
        @(posedge clk);
        #1;
        pre_sin   = 30'h08000000;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_post_sin", post_sin, 32'h0);
        chk("arst_post_cos", post_cos, 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("dropped_no_output", 32'(out_valid), 32'd0);
        send_and_check("post_rst", 1'b1, 2'd0, 30'h04000000, 30'h10000000,
                       32'hBE800000, 32'h3F800000, 2'b00, 32'hBE800000);
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
